dac_spi_array: RTL and testbench

Parametrised multi-channel SPI DAC driver. It shifts one DATA_W-bit word per channel, in parallel, on a shared chip-select and serial clock with one data line per channel, then pulses a shared load strobe. Frames run either single-shot on request or periodically from an internal timer, with a shutdown mode that forces a fixed word. It sits between the sampling controller (which supplies per-channel codes) and the external DAC chips.

---
 rtl/dac_spi_if.sv | 29 ++
 rtl/dac_spi_array.sv | 182 ++++++++++++++++++
 tb/tb_dac_spi_array.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_if.sv
// Bundle between the sampling controller and the multi-channel SPI DAC driver:
// frame control and per-channel codes in, serial bus and status out.
interface dac_spi_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16
);
  logic                     enable;
  logic                     start;
  logic                     auto_mode;
  logic                     shutdown;
  logic [N_CH*DATA_W-1:0]   data_in;
  logic                     cs_n;
  logic                     sck;
  logic [N_CH-1:0]          sdi;
  logic                     ldac_n;
  logic                     busy;
  logic                     done;
  logic                     overrun;

  modport master (
    output enable, start, auto_mode, shutdown, data_in,
    input  cs_n, sck, sdi, ldac_n, busy, done, overrun
  );

  modport slave (
    input  enable, start, auto_mode, shutdown, data_in,
    output cs_n, sck, sdi, ldac_n, busy, done, overrun
  );
endinterface

// File: rtl/dac_spi_array.sv
// Multi-channel SPI DAC driver: one word per channel shifted in parallel on a
// shared cs_n/sck, followed by an ldac_n strobe; single-shot or periodic frames.
module dac_spi_array #(
  parameter int                N_CH      = 4,
  parameter int                DATA_W    = 16,
  parameter int                SCK_DIV   = 4,
  parameter int                CS_SETUP  = 5,
  parameter int                LDAC_W    = 2,
  parameter int                PERIOD    = 81,
  parameter logic [DATA_W-1:0] SHDN_WORD = {DATA_W{1'b0}}
) (
  input  logic     clk,
  input  logic     rst_n,
  dac_spi_if.slave bus
);

  localparam int CNT_MAX = (CS_SETUP > SCK_DIV) ? ((CS_SETUP > LDAC_W) ? CS_SETUP : LDAC_W)
                                                : ((SCK_DIV > LDAC_W) ? SCK_DIV : LDAC_W);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] SCK_LAST   = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] SCK_HALF   = CNT_W'(SCK_DIV / 2);
  localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_W - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LOAD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             ldac_n_q, ldac_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             auto_tick, trigger;
  logic             load_en, shift_en, clear_en;
  logic [N_CH-1:0]  sdi_w;

  // Period timer only runs while auto frames are allowed, so it restarts from 0.
  always_comb begin
    per_d     = '0;
    auto_tick = 1'b0;
    if (bus.enable && bus.auto_mode) begin
      auto_tick = (per_q == PER_LAST);
      per_d     = auto_tick ? '0 : per_q + 1'b1;
    end
    trigger = bus.enable && (bus.start || auto_tick);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      per_q     <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      ldac_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      per_q     <= per_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      ldac_n_q  <= ldac_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    clear_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = SETUP;
          cnt_d   = '0;
          load_en = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // cnt is the phase within one SCK period; the shift lands on the falling edge.
        if (cnt_q == SCK_LAST) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: begin
        if (cnt_q == LDAC_LAST) begin
          state_d  = IDLE;
          clear_en = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every pin comes straight off a flop.
  always_comb begin
    cs_n_d    = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    sck_d     = (state_d == SHIFT) && (cnt_d >= SCK_HALF);
    ldac_n_d  = (state_d != LOAD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == LOAD) && (state_d == IDLE);
    overrun_d = bus.enable && (overrun_q || (auto_tick && busy_q));
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] sh_q, sh_d;

      always_comb begin
        sh_d = sh_q;
        if (load_en) begin
          sh_d = bus.shutdown ? SHDN_WORD : bus.data_in[gi*DATA_W +: DATA_W];
        end else if (shift_en) begin
          sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end else if (clear_en) begin
          sh_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sh_q <= '0;
        end else begin
          sh_q <= sh_d;
        end
      end

      assign sdi_w[gi] = sh_q[DATA_W-1];
    end
  endgenerate

  assign bus.cs_n    = cs_n_q;
  assign bus.sck     = sck_q;
  assign bus.sdi     = sdi_w;
  assign bus.ldac_n  = ldac_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_dac_spi_array.sv
// Self-checking bench for dac_spi_array: table vectors, random frames against a
// word-level model, reset/auto/overrun/enable-drop sequences.
module tb_dac_spi_array;
  localparam int N_CH   = 4;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_if #(.N_CH(N_CH), .DATA_W(DATA_W)) if_a ();
  dac_spi_if #(.N_CH(N_CH), .DATA_W(DATA_W)) if_b ();

  dac_spi_array #(.N_CH(N_CH), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );

  dac_spi_array #(.N_CH(N_CH), .DATA_W(DATA_W), .PERIOD(40)) u_ovr (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor A: recovers words from sdi at sck rises and measures frame timing.
  int          cyc = 0, fall_cyc = 0, done_cyc = 0, cs_low = 0, ldac_low = 0;
  int          rises = 0, done_cnt = 0, bad_cnt = 0;
  logic [15:0] cap [N_CH];
  int          starts_a [$];
  logic        prev_cs = 1'b1, prev_sck = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!if_a.cs_n && prev_cs) begin
        fall_cyc = cyc;
        starts_a.push_back(cyc);
        cs_low   = 0;
        ldac_low = 0;
        rises    = 0;
        for (int k = 0; k < N_CH; k++) cap[k] = '0;
      end
      if (!if_a.cs_n) cs_low++;
      if (!if_a.ldac_n) ldac_low++;
      if (if_a.sck && !prev_sck) begin
        rises++;
        for (int k = 0; k < N_CH; k++) cap[k] = {cap[k][14:0], if_a.sdi[k]};
      end
      if (if_a.sck && if_a.cs_n) bad_cnt++;
      if (!if_a.ldac_n && !if_a.cs_n) bad_cnt++;
      if (if_a.done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      prev_cs  = if_a.cs_n;
      prev_sck = if_a.sck;
    end
  end

  // Monitor B: cs_n low-time statistics for the short-period instance.
  int   b_frames = 0, b_len = 0, b_min = 1000, b_max = 0;
  logic prev_cs_b = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!if_b.cs_n) begin
        if (prev_cs_b) begin
          b_frames++;
          b_len = 0;
        end
        b_len++;
      end else if (!prev_cs_b) begin
        if (b_len < b_min) b_min = b_len;
        if (b_len > b_max) b_max = b_len;
      end
      prev_cs_b = if_b.cs_n;
    end
  end

  typedef struct {
    logic [63:0] data;
    bit          shdn;
    logic [63:0] data_mid;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic wait_done(input int dc0, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_cnt != dc0) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_frame(input logic [63:0] exp, input string tag);
    logic [15:0] w;
    chk({tag, "_rises"}, 64'(rises), 64'd16);
    chk({tag, "_cs_low"}, 64'(cs_low), 64'd70);
    chk({tag, "_ldac_low"}, 64'(ldac_low), 64'd2);
    chk({tag, "_done_at"}, 64'(done_cyc - fall_cyc), 64'd72);
    for (int k = 0; k < N_CH; k++) begin
      w = exp[k*16 +: 16];
      chk($sformatf("%s_ch%0d", tag, k), 64'(cap[k]), 64'(w));
    end
  endtask

  task automatic run_frame(input logic [63:0] d, input bit sh, input logic [63:0] mid,
                           input logic [63:0] exp, input string tag);
    int dc0, t_set;
    dc0 = done_cnt;
    @(posedge clk); #1;
    if_a.data_in  = d;
    if_a.shutdown = sh;
    if_a.start    = 1'b1;
    t_set         = cyc;
    @(posedge clk); #1;
    if_a.start    = 1'b0;
    if_a.shutdown = ~sh;
    if_a.data_in  = mid;
    wait_done(dc0, tag);
    chk({tag, "_latency"}, 64'(fall_cyc - t_set), 64'd2);
    check_frame(exp, tag);
    if_a.shutdown = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_one_done"}, 64'(done_cnt - dc0), 64'd1);
    chk({tag, "_busy_end"}, 64'(if_a.busy), 64'd0);
  endtask

  initial begin
    int   dc0, nf0, nframes;
    logic [63:0] d, mid;
    bit   sh, got;

    vecs[0] = '{64'h3258_3000_A5A5_0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3258_3000_A5A5_0001};
    vecs[1] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[2] = '{64'hFFFF_8000_0000_7FFF, 1'b0, 64'h0,                   64'hFFFF_8000_0000_7FFF};
    vecs[3] = '{64'h5555_AAAA_C3C3_0F0F, 1'b0, 64'h0F0F_C3C3_AAAA_5555, 64'h5555_AAAA_C3C3_0F0F};

    if_a.enable = 1'b0; if_a.start = 1'b0; if_a.auto_mode = 1'b0;
    if_a.shutdown = 1'b0; if_a.data_in = '0;
    if_b.enable = 1'b0; if_b.start = 1'b0; if_b.auto_mode = 1'b0;
    if_b.shutdown = 1'b0; if_b.data_in = 64'hDEAD_BEEF_0123_4567;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(if_a.cs_n), 64'd1);
    chk("rst_sck", 64'(if_a.sck), 64'd0);
    chk("rst_sdi", 64'(if_a.sdi), 64'd0);
    chk("rst_ldac_n", 64'(if_a.ldac_n), 64'd1);
    chk("rst_busy", 64'(if_a.busy), 64'd0);
    chk("rst_done", 64'(if_a.done), 64'd0);
    chk("rst_overrun", 64'(if_a.overrun), 64'd0);
    rst_n = 1'b1;
    if_a.enable = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].data, vecs[v].shdn, vecs[v].data_mid, vecs[v].exp,
                $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      d   = {$urandom, $urandom};
      mid = {$urandom, $urandom};
      sh  = ($urandom_range(0, 3) == 0);
      run_frame(d, sh, mid, sh ? 64'h0 : d, $sformatf("rnd%0d", r));
    end

    // Start ignored while busy: only the first request produces a frame.
    nf0 = starts_a.size();
    dc0 = done_cnt;
    @(posedge clk); #1;
    if_a.data_in = 64'h0102_0304_0506_0708;
    if_a.start   = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("busy_mid", 64'(if_a.busy), 64'd1);
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    wait_done(dc0, "ign");
    check_frame(64'h0102_0304_0506_0708, "ign");
    repeat (20) @(posedge clk);
    #1;
    chk("ign_frames", 64'(starts_a.size() - nf0), 64'd1);

    // Enable dropped mid-frame: frame finishes, no further frames accepted.
    nf0 = starts_a.size();
    dc0 = done_cnt;
    @(posedge clk); #1;
    if_a.data_in = 64'hCAFE_0F0F_8001_7E7E;
    if_a.start   = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    if_a.enable = 1'b0;
    if_a.start  = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    wait_done(dc0, "endrop");
    check_frame(64'hCAFE_0F0F_8001_7E7E, "endrop");
    if_a.start = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    if_a.start = 1'b0;
    chk("endrop_frames", 64'(starts_a.size() - nf0), 64'd1);
    if_a.enable = 1'b1;

    // Reset in the middle of SHIFT.
    dc0 = done_cnt;
    @(posedge clk); #1;
    if_a.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    if_a.start   = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cs_n", 64'(if_a.cs_n), 64'd1);
    chk("midrst_sck", 64'(if_a.sck), 64'd0);
    chk("midrst_sdi", 64'(if_a.sdi), 64'd0);
    chk("midrst_ldac_n", 64'(if_a.ldac_n), 64'd1);
    chk("midrst_busy", 64'(if_a.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst_no_ldac", 64'(ldac_low), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - dc0), 64'd0);

    // Auto mode at PERIOD=81 for 500 cycles: ticks land 81 cycles apart.
    nf0 = starts_a.size();
    @(posedge clk); #1;
    if_a.auto_mode = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    if_a.auto_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!if_a.busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("auto_idle", 64'(got), 64'd1);
    nframes = starts_a.size() - nf0;
    chk("auto_frames", 64'(nframes), 64'd6);
    for (int i = nf0 + 1; i < starts_a.size(); i++) begin
      chk($sformatf("auto_gap%0d", i - nf0), 64'(starts_a[i] - starts_a[i-1]), 64'd81);
    end
    chk("auto_overrun", 64'(if_a.overrun), 64'd0);

    // Overrun on the PERIOD=40 instance.
    @(negedge clk);
    if_b.enable    = 1'b1;
    if_b.auto_mode = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!if_b.cs_n) begin
        got = 1'b1;
        break;
      end
    end
    chk("ovr_first_frame", 64'(got), 64'd1);
    repeat (39) @(negedge clk);
    chk("ovr_before_tick", 64'(if_b.overrun), 64'd0);
    @(negedge clk);
    chk("ovr_at_tick", 64'(if_b.overrun), 64'd1);
    repeat (300) @(negedge clk);
    chk("ovr_sticky", 64'(if_b.overrun), 64'd1);
    chk("ovr_min_cs", 64'(b_min), 64'd70);
    chk("ovr_max_cs", 64'(b_max), 64'd70);
    chk("ovr_frames_ge3", 64'(b_frames >= 3), 64'd1);
    if_b.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_cleared", 64'(if_b.overrun), 64'd0);
    nf0 = b_frames;
    repeat (120) @(negedge clk);
    chk("ovr_no_new", 64'(b_frames - nf0), 64'd0);

    chk("no_glitch", 64'(bad_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
